// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared definitions for the byte-serial control bus (serializer and deserializer sides)
package bus_pkg;

    localparam logic SRC_AES = 1'b0;
    localparam logic SRC_SHA = 1'b1;

    localparam int ADDRW_DEFAULT = 24;
    localparam int OPCODE_LSB    = 0;
    localparam int ADDR_LSB      = 8;

    function automatic int bytes_per_word(input int addrw);
        return (addrw + 8) / 8;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(ADDRW_DEFAULT);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/bus_word_fifo.sv
// rtl/bus_word_fifo.sv - 2-entry first-in first-out buffer for assembled bus words
module bus_word_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok    = pop && (count != 2'd0);
    // A full buffer only takes a word when the head leaves on the same edge.
    assign push_ok   = push && ((count != 2'd2) || pop_ok);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_word_deserializer.sv
// rtl/bus_word_deserializer.sv - rebuilds LSB-first serial bytes into tagged address/opcode words
module bus_word_deserializer
    import bus_pkg::*;
#(
    parameter int ADDRW = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    input  logic             in_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ADDRW-1:0] out_addr,
    output logic [7:0]       out_opcode,
    output logic             out_src,
    output logic             proto_err
);

    localparam int NBYTES = bytes_per_word(ADDRW);
    localparam int W      = ADDRW + 8;
    localparam int CNTW   = $clog2(NBYTES);
    localparam logic [CNTW-1:0] LAST = CNTW'(NBYTES - 1);

    rx_state_e        state;
    rx_state_e        state_n;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  cnt_n;
    logic             cur_src;
    logic             src_n;
    logic [ADDRW-1:0] asm_q;
    logic [ADDRW-1:0] asm_n;
    logic [ADDRW-1:0] asm_shift;
    logic             err_n;
    logic             accept;
    logic             push;
    logic             pop;
    logic [1:0]       fifo_count;
    logic [W:0]       push_data;
    logic [W:0]       head_data;

    assign in_ready  = (cnt != LAST) || (fifo_count != 2'd2);
    assign accept    = in_valid && in_ready;
    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;

    // Earlier bytes shift down so byte 0 lands at bit 0 once the final byte arrives.
    assign asm_shift = ADDRW'({in_byte, asm_q} >> 8);
    assign push_data = {cur_src, in_byte, asm_q};

    assign out_opcode = head_data[OPCODE_LSB +: 8];
    assign out_addr   = head_data[ADDR_LSB +: ADDRW];
    assign out_src    = head_data[W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cur_src   <= SRC_AES;
            asm_q     <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cur_src   <= src_n;
            asm_q     <= asm_n;
            proto_err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        src_n   = cur_src;
        asm_n   = asm_q;
        err_n   = 1'b0;
        push    = 1'b0;
        if (accept) begin
            if ((state == ST_IDLE) || (in_src != cur_src)) begin
                // A source change abandons the partial word; this byte starts a new one.
                err_n   = (state == ST_COLLECT);
                src_n   = in_src;
                cnt_n   = CNTW'(1);
                asm_n   = asm_shift;
                state_n = ST_COLLECT;
            end else if (cnt == LAST) begin
                push    = 1'b1;
                cnt_n   = '0;
                state_n = ST_IDLE;
            end else begin
                cnt_n = cnt + CNTW'(1);
                asm_n = asm_shift;
            end
        end
    end

    bus_word_fifo #(
        .WIDTH(W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_bus_word_deserializer.sv
// tb/tb_bus_word_deserializer.sv - scoreboard bench for bus_word_deserializer
module tb_bus_word_deserializer;

    localparam int ADDRW = 24;
    localparam int NB    = 4;
    localparam int W     = 32;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [7:0]       in_byte   = 8'h00;
    logic             in_src    = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [ADDRW-1:0] out_addr;
    logic [7:0]       out_opcode;
    logic             out_src;
    logic             proto_err;

    bus_word_deserializer #(
        .ADDRW(ADDRW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .in_src     (in_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_opcode (out_opcode),
        .out_src    (out_src),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         errors   = 0;
    int         stalls   = 0;
    int         err_seen = 0;
    bit         rnd_rdy  = 1'b0;
    bit         err_flag = 1'b0;
    logic [7:0] part[$];
    logic       part_src = 1'b0;
    logic [W:0] expq[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: a word is the NB most recent same-source bytes, byte k weighted by 256**k.
    task automatic model_accept(input logic [7:0] b, input logic s);
        logic [W-1:0] w;
        if (part.size() != 0 && s != part_src) begin
            err_flag = 1'b1;
            part.delete();
        end
        if (part.size() == 0) part_src = s;
        part.push_back(b);
        if (part.size() == NB) begin
            w = '0;
            for (int k = 0; k < NB; k++) w = w + (W'(part[k]) << (8 * k));
            expq.push_back({s, w});
            part.delete();
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic s);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        in_src   = s;
        for (int i = 0; i < 200 && !done; i++) begin
            #7;
            chk("in_ready", in_ready, !(part.size() == NB - 1 && expq.size() == 2));
            done = in_ready;
            if (!done) stalls++;
            @(posedge clk);
            if (done) model_accept(b, s);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=stalled exp=accepted byte=%0h", b);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic s);
        for (int k = 0; k < NB; k++) send_byte(w[8*k +: 8], s);
    endtask

    initial begin : monitor
        bit do_pop;
        forever begin
            @(negedge clk);
            do_pop = 1'b0;
            chk("out_valid", out_valid, expq.size() != 0);
            if (out_valid === 1'b1 && expq.size() != 0) begin
                chk("out_word", {out_src, out_addr, out_opcode}, expq[0]);
                do_pop = (out_ready === 1'b1);
            end
            chk("proto_err", proto_err, err_flag);
            if (proto_err === 1'b1) err_seen++;
            err_flag = 1'b0;
            @(posedge clk);
            if (do_pop) void'(expq.pop_front());
        end
    end

    initial begin : rand_ready
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          s0;
        int          e0;
        logic [31:0] wa;
        logic [31:0] wb;

        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_opcode", out_opcode, 0);
        chk("rst_out_src", out_src, 0);
        sync();
        rst_n = 1'b1;
        sync();

        // AES single word
        out_ready = 1'b1;
        send_word(32'hA1B2C3D4, 1'b0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_addr", out_addr, 24'hA1B2C3);
        chk("t1_opcode", out_opcode, 8'hD4);
        chk("t1_src", out_src, 0);
        sync();
        repeat (2) sync();

        // Backpressure with two buffered words
        out_ready = 1'b0;
        send_word(32'h11223344, 1'b1);
        send_word(32'h55667788, 1'b1);
        s0 = stalls;
        fork
            send_word(32'h99AABBCC, 1'b1);
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        chk("bp_stalled", stalls > s0, 1);
        repeat (6) sync();

        // Source switch mid-word
        e0 = err_seen;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(32'h40302010, 1'b1);
        @(negedge clk);
        chk("sw_addr", out_addr, 24'h403020);
        chk("sw_opcode", out_opcode, 8'h10);
        chk("sw_src", out_src, 1);
        sync();
        repeat (2) sync();
        chk("sw_err_pulses", err_seen - e0, 1);

        // Push and pop on the same edge with one word buffered
        out_ready = 1'b0;
        wa = $urandom;
        wb = $urandom;
        send_word(wa, 1'b0);
        s0 = stalls;
        for (int k = 0; k < NB - 1; k++) send_byte(wb[8*k +: 8], 1'b1);
        out_ready = 1'b1;
        send_byte(wb[31:24], 1'b1);
        out_ready = 1'b0;
        @(negedge clk);
        chk("pp_valid", out_valid, 1);
        chk("pp_addr", out_addr, wb[31:8]);
        chk("pp_opcode", out_opcode, wb[7:0]);
        chk("pp_no_stall", stalls - s0, 0);
        sync();
        out_ready = 1'b1;
        repeat (3) sync();

        // Reset mid-word
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        rst_n = 1'b0;
        part.delete();
        expq.delete();
        err_flag = 1'b0;
        #2;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_proto_err", proto_err, 0);
        sync();
        rst_n = 1'b1;
        e0 = err_seen;
        send_word(32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("mr_addr", out_addr, 24'hDEADBE);
        chk("mr_opcode", out_opcode, 8'hEF);
        chk("mr_src", out_src, 0);
        chk("mr_no_err", err_seen - e0, 0);
        sync();
        repeat (2) sync();

        // Back-to-back alternating sources with random downstream readiness
        rnd_rdy = 1'b1;
        for (int i = 0; i < 8; i++) send_word($urandom, i[0]);
        rnd_rdy   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && expq.size() != 0; i++) sync();
        chk("drain_empty", expq.size(), 0);
        repeat (2) sync();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
